// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants and helpers for the round-robin arbiter
//               multiplexor family (arbitration mode encodings, index width).
// Revision    : 1.0  initial release
// ============================================================================
package arb_pkg;

    // Arbitration mode encodings used by the ARB_MODE parameter
    localparam int unsigned ARB_RR    = 0;  // rotating priority
    localparam int unsigned ARB_FIXED = 1;  // channel 0 always highest

    // Number of bits needed to hold an index 0..n-1, never less than one so
    // that index ports stay legal even for degenerate widths.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant
// Description : Purely combinational N_IN-wide arbiter. Produces a one-hot
//               grant and its binary index from a request vector, a rotating
//               priority pointer and a mode select (round-robin / fixed).
// Revision    : 1.0  initial release
// ============================================================================
module rr_grant
    import arb_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = clog2_min1(N_IN)
) (
    input  logic [N_IN-1:0]  req_i,    // per-channel request
    input  logic [SEL_W-1:0] ptr_i,    // highest-priority channel in RR mode
    input  logic             mode_i,   // 0 = round-robin, 1 = fixed priority
    output logic [N_IN-1:0]  grant_o,  // one-hot grant, zero when no request
    output logic [SEL_W-1:0] idx_o,    // binary index of the granted channel
    output logic             valid_o   // at least one request present
);

    // Two-pass search: first the channels at or above the pointer, then the
    // wrapped-around channels below it. In fixed mode the first pass covers
    // every channel starting from 0, so the pointer is effectively ignored.
    always_comb begin : p_search
        logic w_found;
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (!w_found && req_i[i] && (mode_i || (i >= int'(ptr_i)))) begin
                w_found    = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = SEL_W'(i);
            end
        end
        for (int i = 0; i < int'(N_IN); i++) begin
            if (!w_found && req_i[i]) begin
                w_found    = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = SEL_W'(i);
            end
        end
    end

    // Any request at all means a grant is issued
    assign valid_o = |req_i;

endmodule : rr_grant
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux
// Description : N_IN-channel valid/ready multiplexor with round-robin or
//               fixed-priority arbitration and a single registered
//               valid/ready output stage (1-cycle latency, full throughput).
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb_mux
    import arb_pkg::*;
#(
    parameter  int unsigned WIDTH    = 5,
    parameter  int unsigned N_IN     = 4,
    parameter  int unsigned ARB_MODE = ARB_RR,
    localparam int unsigned SEL_W    = clog2_min1(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN-1:0]       in_valid_i,
    input  logic [N_IN*WIDTH-1:0] in_data_i,
    output logic [N_IN-1:0]       in_ready_o,
    output logic                  out_valid_o,
    output logic [WIDTH-1:0]      out_data_o,
    output logic [SEL_W-1:0]      out_sel_o,
    input  logic                  out_ready_i
);

    localparam logic             c_FIXED  = (ARB_MODE == ARB_FIXED);
    localparam logic [SEL_W-1:0] c_LAST   = SEL_W'(N_IN - 1);

    // Output register and rotating pointer
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    // Combinational arbitration / handshake
    logic [N_IN-1:0]  w_grant;
    logic [SEL_W-1:0] w_idx;
    logic             w_any_req;
    logic             w_can_load;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    rr_grant #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_grant (
        .req_i   (in_valid_i),
        .ptr_i   (ptr_q),
        .mode_i  (c_FIXED),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .valid_o (w_any_req)
    );

    // The output slot can accept new data when empty or being drained now
    assign w_can_load = ~out_valid_q | out_ready_i;

    // Ready is forced low while reset is held so no producer sees a
    // handshake that the (reset) register would then discard.
    assign in_ready_o = (rst_n && w_any_req) ? (w_grant & {N_IN{w_can_load}})
                                             : '0;

    // Grant already implies the matching valid, so any ready bit is a transfer
    assign w_xfer = |in_ready_o;

    // AND-OR data mux driven by the one-hot grant
    always_comb begin : p_data_mux
        w_sel_data = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (w_grant[i]) begin
                w_sel_data = in_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: load on transfer, otherwise drop valid once drained
    always_comb begin : p_next
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sel_data;
            out_sel_d   = w_idx;
            if (!c_FIXED) begin
                ptr_d = (w_idx == c_LAST) ? '0 : (w_idx + 1'b1);
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

endmodule : rr_arb_mux
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_mux
// Description : Self-checking bench for rr_arb_mux. A round-robin instance is
//               driven from a vector table with a data scoreboard; a
//               fixed-priority instance shares the inputs and is checked in
//               hand-written sequences. Reset behaviour is checked directly.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arb_mux;

    localparam int unsigned WIDTH = 5;
    localparam int unsigned N_IN  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN*WIDTH-1:0] in_data;
    logic                  out_ready;

    logic [N_IN-1:0]  rr_ready,  fx_ready;
    logic             rr_ovalid, fx_ovalid;
    logic [WIDTH-1:0] rr_odata,  fx_odata;
    logic [1:0]       rr_osel,   fx_osel;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] data;
        logic [1:0] sel;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] v;      // in_valid driven this cycle
        logic       ordy;   // out_ready driven this cycle
        logic [3:0] rdy;    // expected in_ready before the edge
        logic       ov;     // expected out_valid after the edge
    } vec_t;
    vec_t tbl[21];

    rr_arb_mux #(.WIDTH(WIDTH), .N_IN(N_IN), .ARB_MODE(0)) dut_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (rr_ready),
        .out_valid_o (rr_ovalid),
        .out_data_o  (rr_odata),
        .out_sel_o   (rr_osel),
        .out_ready_i (out_ready)
    );

    rr_arb_mux #(.WIDTH(WIDTH), .N_IN(N_IN), .ARB_MODE(1)) dut_fx (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (fx_ready),
        .out_valid_o (fx_ovalid),
        .out_data_o  (fx_odata),
        .out_sel_o   (fx_osel),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Vector table for the round-robin instance, starting with ptr=0
        tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1};  // single requester ch2
        tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1};
        tbl[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b1};
        tbl[3]  = '{4'b1000, 1'b1, 4'b1000, 1'b1};  // ch3 -> ptr wraps to 0
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};  // fairness 0,1,2,3,0,1
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
        tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1};  // backpressure x3 holding ch1
        tbl[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[12] = '{4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[13] = '{4'b1111, 1'b1, 4'b0100, 1'b1};  // release: ch2 next
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0};  // drain
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[16] = '{4'b1000, 1'b1, 4'b1000, 1'b1};  // grant ch3
        tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0};  // idle x2
        tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[19] = '{4'b1001, 1'b1, 4'b0001, 1'b1};  // wrapped ptr picks ch0
        tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b0};

        for (int i = 0; i < int'(N_IN); i++) begin
            in_data[i*WIDTH +: WIDTH] = 5'(5'h10 + i);
        end

        // Power-on reset with all channels requesting
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #2;
        chk("reset_in_ready",  32'(rr_ready),  32'h0);
        chk("reset_out_valid", 32'(rr_ovalid), 32'h0);
        chk("reset_out_data",  32'(rr_odata),  32'h0);
        chk("reset_out_sel",   32'(rr_osel),   32'h0);
        @(negedge clk);
        @(negedge clk);
        in_valid = 4'b0000;
        rst_n    = 1'b1;

        // Table-driven run with scoreboard on the round-robin instance
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            in_valid  = tbl[i].v;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(rr_ready), 32'(tbl[i].rdy));
            if (rr_ovalid) begin
                if (sb.size() == 0) begin
                    chk($sformatf("vec%0d_unexpected_out_valid", i), 32'(rr_ovalid), 32'h0);
                end else begin
                    chk($sformatf("vec%0d_out_data", i), 32'(rr_odata), 32'(sb[0].data));
                    chk($sformatf("vec%0d_out_sel", i),  32'(rr_osel),  32'(sb[0].sel));
                    if (out_ready) begin
                        void'(sb.pop_front());
                    end
                end
            end
            for (int k = 0; k < int'(N_IN); k++) begin
                if (tbl[i].rdy[k]) begin
                    sb.push_back(exp_t'({5'(5'h10 + k), 2'(k)}));
                end
            end
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(rr_ovalid), 32'(tbl[i].ov));
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        // Reset asserted mid-cycle while the output holds data
        @(negedge clk);
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", 32'(rr_ovalid), 32'h1);
        chk("pre_reset_out_data",  32'(rr_odata),  32'h12);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(rr_ovalid), 32'h0);
        chk("midreset_out_data",  32'(rr_odata),  32'h0);
        chk("midreset_out_sel",   32'(rr_osel),   32'h0);
        chk("midreset_in_ready",  32'(rr_ready),  32'h0);
        sb.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        #1;
        chk("post_reset_ptr_zero", 32'(rr_ready), 32'h1);

        // Fixed priority: ch1 starves ch3 until ch1 drops
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            in_valid = 4'b1010;
            #1;
            chk($sformatf("fixed%0d_in_ready", n), 32'(fx_ready), 32'h2);
            @(posedge clk);
            #1;
            chk($sformatf("fixed%0d_out_valid", n), 32'(fx_ovalid), 32'h1);
            chk($sformatf("fixed%0d_out_sel", n),   32'(fx_osel),   32'h1);
            chk($sformatf("fixed%0d_out_data", n),  32'(fx_odata),  32'h11);
        end
        @(negedge clk);
        in_valid = 4'b1000;
        #1;
        chk("fixed_drop_in_ready", 32'(fx_ready), 32'h8);
        @(posedge clk);
        #1;
        chk("fixed_drop_out_sel",  32'(fx_osel),  32'h3);
        chk("fixed_drop_out_data", 32'(fx_odata), 32'h13);
        @(negedge clk);
        in_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("final_out_valid", 32'(fx_ovalid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_arb_mux
`default_nettype wire
